// File: rtl/sum_window_accumulator.sv
// -----------------------------------------------------------------------------
// sum_window_accumulator
//
// Sums a window of NSAMP accepted samples from the adder and counts how many
// of those samples carried the zero flag. Each finished window is offered on
// a valid/ready output handshake. New samples are not accepted while a
// finished result is waiting to be taken.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   clear        in   synchronous abort of the current window (active high)
//   in_valid     in   in_sum / in_zero valid this cycle
//   in_sum       in   [SWIDTH-1:0] sum sample from the adder
//   in_zero      in   sample-is-zero flag from the adder
//   in_ready     out  a sample is accepted this cycle when in_valid is high
//   out_valid    out  window result available
//   out_acc      out  [ACCW-1:0] sum of the NSAMP samples of the window
//   out_zero_cnt out  [CNTW-1:0] number of window samples with in_zero=1
//   out_ready    in   downstream takes the result
// -----------------------------------------------------------------------------
module sum_window_accumulator #(
    parameter int SWIDTH = 9,
    parameter int NSAMP  = 8,
    parameter int ACCW   = 12,
    parameter int CNTW   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [SWIDTH-1:0] in_sum,
    input  logic              in_zero,
    output logic              in_ready,
    output logic              out_valid,
    output logic [ACCW-1:0]   out_acc,
    output logic [CNTW-1:0]   out_zero_cnt,
    input  logic              out_ready
);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam logic [CNTW-1:0] LAST_IDX = CNTW'(NSAMP - 1);

    state_t          state_r;
    state_t          state_next_s;
    logic [ACCW-1:0] acc_r;
    logic [CNTW-1:0] zcnt_r;
    logic [CNTW-1:0] idx_r;
    logic [ACCW-1:0] out_acc_r;
    logic [CNTW-1:0] out_zero_cnt_r;

    logic            in_ready_s;
    logic            out_valid_s;
    logic            accept_s;
    logic            last_s;
    logic [ACCW-1:0] acc_sum_s;
    logic [CNTW-1:0] zcnt_sum_s;

    // Running totals including the sample currently presented.
    always_comb begin
        acc_sum_s  = acc_r + ACCW'(in_sum);
        zcnt_sum_s = zcnt_r + CNTW'(in_zero);
        // A sample presented together with clear is dropped.
        accept_s   = in_valid & in_ready_s & ~clear;
        last_s     = (idx_r == LAST_IDX);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_ACCUM;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; clear overrides both accept and out_ready.
    always_comb begin
        state_next_s = state_r;
        if (clear) begin
            state_next_s = ST_ACCUM;
        end else begin
            case (state_r)
                ST_ACCUM: begin
                    if (accept_s && last_s) begin
                        state_next_s = ST_HOLD;
                    end else begin
                        state_next_s = ST_ACCUM;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_next_s = ST_ACCUM;
                    end else begin
                        state_next_s = ST_HOLD;
                    end
                end
                default: state_next_s = ST_ACCUM;
            endcase
        end
    end

    // Handshake outputs decoded from the state register; in_ready is forced
    // low while reset is asserted.
    always_comb begin
        case (state_r)
            ST_ACCUM: begin
                in_ready_s  = rst_n;
                out_valid_s = 1'b0;
            end
            ST_HOLD: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b1;
            end
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Window accumulation and result capture. The result registers are only
    // written on the last accept, so they stay stable throughout HOLD and
    // keep their value across a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r          <= {ACCW{1'b0}};
            zcnt_r         <= {CNTW{1'b0}};
            idx_r          <= {CNTW{1'b0}};
            out_acc_r      <= {ACCW{1'b0}};
            out_zero_cnt_r <= {CNTW{1'b0}};
        end else if (clear) begin
            acc_r  <= {ACCW{1'b0}};
            zcnt_r <= {CNTW{1'b0}};
            idx_r  <= {CNTW{1'b0}};
        end else if (accept_s) begin
            if (last_s) begin
                out_acc_r      <= acc_sum_s;
                out_zero_cnt_r <= zcnt_sum_s;
                acc_r          <= {ACCW{1'b0}};
                zcnt_r         <= {CNTW{1'b0}};
                idx_r          <= {CNTW{1'b0}};
            end else begin
                acc_r  <= acc_sum_s;
                zcnt_r <= zcnt_sum_s;
                idx_r  <= idx_r + CNTW'(1);
            end
        end else begin
            acc_r <= acc_r;
        end
    end

    assign in_ready     = in_ready_s;
    assign out_valid    = out_valid_s;
    assign out_acc      = out_acc_r;
    assign out_zero_cnt = out_zero_cnt_r;

endmodule

// File: doc/sum_window_accumulator.md
Name: sum_window_accumulator

Overview:
- Downstream consumer of the registered adder outputs (sm_r, sm_zero_r).
- Accumulates a window of NSAMP accepted sums and counts how many of them were zero.
- Presents each completed window result on a valid/ready output handshake to the next stage (readout or checker logic).
- Stalls input acceptance while a completed result waits to be taken.

Parameters:
- SWIDTH, 9, width of an incoming sum; matches the adder's SWIDTH (WIDTH+1 with WIDTH=8).
- NSAMP, 8, samples per window; legal range 2..256.
- ACCW, 12, accumulator width; must be >= SWIDTH+clog2(NSAMP).
- CNTW, 4, zero-count and sample-index width; must be >= clog2(NSAMP+1).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous abort of the current window; active high.
- in_valid  input  1  in_sum/in_zero are valid this cycle.
- in_sum  input  SWIDTH  sum sample, driven from adder sm_r.
- in_zero  input  1  sample-is-zero flag, driven from adder sm_zero_r.
- in_ready  output  1  block accepts a sample this cycle.
- out_valid  output  1  window result available.
- out_acc  output  ACCW  sum of NSAMP samples.
- out_zero_cnt  output  CNTW  number of samples in the window with in_zero=1.
- out_ready  input  1  downstream takes the result.

Behaviour:
- Reset values: in_ready=0 during reset; in_ready=1 in the first cycle after deassertion. out_valid=0, out_acc=0, out_zero_cnt=0. Internal acc, zcnt and idx are 0. State is ACCUM.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Accept: a sample is accepted when in_valid && in_ready at a rising clk edge.
  - acc <= acc + zero-extended in_sum.
  - zcnt <= zcnt + in_zero.
  - idx <= idx + 1.
- Window end: on accepting the sample with idx==NSAMP-1:
  - out_acc <= acc + in_sum; out_zero_cnt <= zcnt + in_zero.
  - acc, zcnt and idx cleared to 0; state -> HOLD.
  - out_valid rises the cycle after the last accept (latency 1).
- HOLD:
  - out_acc and out_zero_cnt are held stable while out_valid && !out_ready.
  - On out_ready: state -> ACCUM, out_valid=0 next cycle, in_ready=1 next cycle.
  - There is no same-cycle bypass; there is always one bubble cycle between windows.
- Width rule: acc wraps modulo 2^ACCW. There is no saturation. With legal parameters, overflow cannot occur.
- in_zero is trusted as given. The block does not cross-check it against in_sum.
- clear: takes priority over accept and over out_ready in the same cycle.
  - Zeroes acc, zcnt and idx; forces state -> ACCUM and out_valid -> 0.
  - out_acc and out_zero_cnt keep their last values; they are don't-care when out_valid=0.
  - A sample presented in the same cycle as clear is dropped.
- Asynchronous reset mid-window or mid-HOLD returns everything to reset values immediately. The partial window is lost.
- in_valid while in_ready=0 has no effect. The upstream adder output is free-running, so the sample is not held and is simply not counted.
- out_ready while out_valid=0 is ignored.

Test Plan:
- Reset then 8 back-to-back samples in_sum=1..8, in_zero=0, out_ready=1 -> out_valid pulses 1 cycle, starting the cycle after the 8th accept; out_acc=36, out_zero_cnt=0.
- Samples 0,5,0,0,511,0,2,0 with matching in_zero -> out_acc=518, out_zero_cnt=5.
- Backpressure: out_ready=0 for 10 cycles after window done, in_valid held 1 -> in_ready=0 and outputs stable throughout. Raise out_ready -> out_valid=0 and in_ready=1 next cycle; next window counts from sample 0.
- 8 samples of 511 -> out_acc=4088 (no wrap at ACCW=12).
- clear asserted after 5 accepts with in_valid=1 -> that sample is dropped. The next 8 samples of 3 give out_acc=24. A clear during HOLD drops out_valid the next cycle.
- rst_n low for 1 cycle in mid-window after 3 accepts -> all outputs 0 immediately. After release, a full fresh 8-sample window is required before out_valid.
